// File: rtl/control_estacionamiento.sv
// Parking-lot occupancy controller: tracks A/B barrier passages to count cars in and out,
// with a saturating count, full/empty flags and one-cycle event pulses.
module control_estacionamiento #(
    parameter int unsigned CAPACIDAD = 15,
    parameter int unsigned ANCHO     = 4,
    parameter int unsigned TIMEOUT   = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_a,
    input  logic             sensor_b,
    output logic [ANCHO-1:0] ocupacion,
    output logic             lleno,
    output logic             vacio,
    output logic             pulso_entrada,
    output logic             pulso_salida,
    output logic             rechazo,
    output logic             error,
    output logic [2:0]       estado
);

    localparam int unsigned AnchoTimer = $clog2(TIMEOUT);
    localparam logic [AnchoTimer-1:0] TimerMax = AnchoTimer'(TIMEOUT - 1);
    localparam logic [ANCHO-1:0] Capacidad = ANCHO'(CAPACIDAD);

    typedef enum logic [2:0] {
        StReposo = 3'd0,
        StEntA   = 3'd1,
        StEntAb  = 3'd2,
        StEntB   = 3'd3,
        StSalB   = 3'd4,
        StSalBa  = 3'd5,
        StSalA   = 3'd6,
        StEspera = 3'd7
    } estado_t;

    estado_t               estado_q, estado_d;
    logic [AnchoTimer-1:0] timer_q, timer_d;
    logic [ANCHO-1:0]      ocupacion_q, ocupacion_d;
    logic                  pulso_entrada_q, pulso_entrada_d;
    logic                  pulso_salida_q, pulso_salida_d;
    logic                  rechazo_q, rechazo_d;
    logic                  error_q, error_d;

    logic [1:0] ab;
    logic       transicion;
    logic       intermedio;
    logic       evento_entrada;
    logic       evento_salida;
    logic       error_secuencia;

    assign ab = {sensor_a, sensor_b};

    always_comb begin
        estado_d        = estado_q;
        transicion      = 1'b1;
        evento_entrada  = 1'b0;
        evento_salida   = 1'b0;
        error_secuencia = 1'b0;
        intermedio      = (estado_q != StReposo) && (estado_q != StEspera);

        unique case (estado_q)
            StReposo: begin
                case (ab)
                    2'b10:   estado_d = StEntA;
                    2'b01:   estado_d = StSalB;
                    2'b11: begin
                        estado_d        = StEspera;
                        error_secuencia = 1'b1;
                    end
                    default: transicion = 1'b0;
                endcase
            end
            StEntA: begin
                case (ab)
                    2'b11:   estado_d = StEntAb;
                    2'b00:   estado_d = StReposo;
                    2'b01: begin
                        estado_d        = StEspera;
                        error_secuencia = 1'b1;
                    end
                    default: transicion = 1'b0;
                endcase
            end
            StEntAb: begin
                case (ab)
                    2'b01:   estado_d = StEntB;
                    2'b10:   estado_d = StEntA;
                    2'b00: begin
                        estado_d        = StEspera;
                        error_secuencia = 1'b1;
                    end
                    default: transicion = 1'b0;
                endcase
            end
            StEntB: begin
                case (ab)
                    2'b00: begin
                        estado_d       = StReposo;
                        evento_entrada = 1'b1;
                    end
                    2'b11:   estado_d = StEntAb;
                    2'b10: begin
                        estado_d        = StEspera;
                        error_secuencia = 1'b1;
                    end
                    default: transicion = 1'b0;
                endcase
            end
            StSalB: begin
                case (ab)
                    2'b11:   estado_d = StSalBa;
                    2'b00:   estado_d = StReposo;
                    2'b10: begin
                        estado_d        = StEspera;
                        error_secuencia = 1'b1;
                    end
                    default: transicion = 1'b0;
                endcase
            end
            StSalBa: begin
                case (ab)
                    2'b10:   estado_d = StSalA;
                    2'b01:   estado_d = StSalB;
                    2'b00: begin
                        estado_d        = StEspera;
                        error_secuencia = 1'b1;
                    end
                    default: transicion = 1'b0;
                endcase
            end
            StSalA: begin
                case (ab)
                    2'b00: begin
                        estado_d      = StReposo;
                        evento_salida = 1'b1;
                    end
                    2'b11:   estado_d = StSalBa;
                    2'b01: begin
                        estado_d        = StEspera;
                        error_secuencia = 1'b1;
                    end
                    default: transicion = 1'b0;
                endcase
            end
            StEspera: begin
                if (ab == 2'b00) begin
                    estado_d = StReposo;
                end else begin
                    transicion = 1'b0;
                end
            end
            default: estado_d = StReposo;
        endcase

        // A listed transition always wins over the timeout
        if (!transicion && intermedio && (timer_q == TimerMax)) begin
            estado_d        = StEspera;
            error_secuencia = 1'b1;
        end
    end

    always_comb begin
        ocupacion_d     = ocupacion_q;
        pulso_entrada_d = 1'b0;
        pulso_salida_d  = 1'b0;
        rechazo_d       = 1'b0;
        error_d         = error_secuencia;

        if (evento_entrada) begin
            if (ocupacion_q < Capacidad) begin
                ocupacion_d     = ocupacion_q + 1'b1;
                pulso_entrada_d = 1'b1;
            end else begin
                rechazo_d = 1'b1;
            end
        end

        if (evento_salida) begin
            if (ocupacion_q != '0) begin
                ocupacion_d    = ocupacion_q - 1'b1;
                pulso_salida_d = 1'b1;
            end else begin
                error_d = 1'b1;
            end
        end

        if ((estado_d != estado_q) || (estado_d == StReposo) || (estado_d == StEspera)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q        <= StReposo;
            timer_q         <= '0;
            ocupacion_q     <= '0;
            pulso_entrada_q <= 1'b0;
            pulso_salida_q  <= 1'b0;
            rechazo_q       <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            estado_q        <= estado_d;
            timer_q         <= timer_d;
            ocupacion_q     <= ocupacion_d;
            pulso_entrada_q <= pulso_entrada_d;
            pulso_salida_q  <= pulso_salida_d;
            rechazo_q       <= rechazo_d;
            error_q         <= error_d;
        end
    end

    assign ocupacion     = ocupacion_q;
    assign lleno         = (ocupacion_q == Capacidad);
    assign vacio         = (ocupacion_q == '0);
    assign pulso_entrada = pulso_entrada_q;
    assign pulso_salida  = pulso_salida_q;
    assign rechazo       = rechazo_q;
    assign error         = error_q;
    assign estado        = estado_q;

endmodule

// File: tb/tb_control_estacionamiento.sv
// Bench for control_estacionamiento: a behavioural model predicts each cycle's outputs into a
// queue, which is drained and compared once the DUT has taken the corresponding edge.
module tb_control_estacionamiento;

    localparam int unsigned CAP = 3;
    localparam int unsigned W   = 2;
    localparam int unsigned TO  = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sensor_a = 1'b0;
    logic         sensor_b = 1'b0;
    logic [W-1:0] ocupacion;
    logic         lleno, vacio, pulso_entrada, pulso_salida, rechazo, error;
    logic [2:0]   estado;

    control_estacionamiento #(
        .CAPACIDAD(CAP),
        .ANCHO    (W),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensor_a     (sensor_a),
        .sensor_b     (sensor_b),
        .ocupacion    (ocupacion),
        .lleno        (lleno),
        .vacio        (vacio),
        .pulso_entrada(pulso_entrada),
        .pulso_salida (pulso_salida),
        .rechazo      (rechazo),
        .error        (error),
        .estado       (estado)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int occ;
        int pulses;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_state = 0;
    int   m_timer = 0;
    int   m_occ = 0;
    int   n_pin = 0, n_pout = 0, n_rej = 0, n_err = 0;

    task automatic check_eq(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_timer = 0;
        m_occ   = 0;
        exp_q.delete();
    endtask

    // Phase-based model: entry and exit share one three-phase walk with a/b swapped
    task automatic model_step(input bit a, input bit b);
        int nxt, p, np;
        bit dir_in, x, y, fin, ev_in, ev_out, err, pin, pout, rej;
        exp_t e;
        nxt = m_state;
        fin = 0; ev_in = 0; ev_out = 0; err = 0; pin = 0; pout = 0; rej = 0;
        if (m_state == 0) begin
            if (a && !b) nxt = 1;
            else if (!a && b) nxt = 4;
            else if (a && b) begin nxt = 7; err = 1; end
        end else if (m_state == 7) begin
            if (!a && !b) nxt = 0;
        end else begin
            dir_in = (m_state <= 3);
            p  = dir_in ? m_state : m_state - 3;
            x  = dir_in ? a : b;
            y  = dir_in ? b : a;
            np = -1;
            case (p)
                1: if (x && y) np = 2; else if (!x && !y) np = 0; else if (!x && y) np = 7;
                2: if (!x && y) np = 3; else if (x && !y) np = 1; else if (!x && !y) np = 7;
                default: begin
                    if (!x && !y) begin np = 0; fin = 1; end
                    else if (x && y) np = 2;
                    else if (x && !y) np = 7;
                end
            endcase
            if (np == -1) begin
                if (m_timer == TO - 1) begin nxt = 7; err = 1; end
            end else if (np == 7) begin
                nxt = 7; err = 1;
            end else if (np == 0) begin
                nxt = 0;
                if (fin) begin ev_in = dir_in; ev_out = !dir_in; end
            end else begin
                nxt = dir_in ? np : np + 3;
            end
        end
        if (ev_in) begin
            if (m_occ < CAP) begin m_occ++; pin = 1; end else rej = 1;
        end
        if (ev_out) begin
            if (m_occ > 0) begin m_occ--; pout = 1; end else err = 1;
        end
        if (nxt != m_state || nxt == 0 || nxt == 7) m_timer = 0;
        else m_timer++;
        m_state  = nxt;
        e.st     = nxt;
        e.occ    = m_occ;
        e.pulses = {28'd0, pin, pout, rej, err};
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit a, input bit b);
        exp_t e;
        sensor_a = a;
        sensor_b = b;
        model_step(a, b);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_eq("estado", int'(estado), e.st);
            check_eq("ocupacion", int'(ocupacion), e.occ);
            check_eq("lleno", int'(lleno), int'(e.occ == CAP));
            check_eq("vacio", int'(vacio), int'(e.occ == 0));
            check_eq("pulses", int'({pulso_entrada, pulso_salida, rechazo, error}), e.pulses);
        end
        n_pin  += int'(pulso_entrada);
        n_pout += int'(pulso_salida);
        n_rej  += int'(rechazo);
        n_err  += int'(error);
    endtask

    task automatic hold(input bit a, input bit b, input int n);
        for (int i = 0; i < n; i++) drive(a, b);
    endtask

    task automatic clear_counts();
        n_pin = 0; n_pout = 0; n_rej = 0; n_err = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_estado"}, int'(estado), 0);
        check_eq({tag, "_ocupacion"}, int'(ocupacion), 0);
        check_eq({tag, "_vacio"}, int'(vacio), 1);
        check_eq({tag, "_lleno"}, int'(lleno), 0);
        check_eq({tag, "_pulses"}, int'({pulso_entrada, pulso_salida, rechazo, error}), 0);
    endtask

    // Mid-cycle asynchronous reset: outputs must clear before the next clock edge
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        check_reset_outputs("por");
        model_reset();
        #6;
        rst_n = 1'b1;

        // Full entry
        clear_counts();
        hold(1, 0, 5); hold(1, 1, 5); hold(0, 1, 5); hold(0, 0, 5);
        check_eq("entry_occ", int'(ocupacion), 1);
        check_eq("entry_pulse_count", n_pin, 1);

        // Full exit, then exit while empty
        clear_counts();
        hold(0, 1, 5); hold(1, 1, 5); hold(1, 0, 5); hold(0, 0, 5);
        check_eq("exit_occ", int'(ocupacion), 0);
        check_eq("exit_pulse_count", n_pout, 1);
        clear_counts();
        hold(0, 1, 5); hold(1, 1, 5); hold(1, 0, 5); hold(0, 0, 5);
        check_eq("exit_empty_err", n_err, 1);
        check_eq("exit_empty_pout", n_pout, 0);

        // Aborts
        clear_counts();
        hold(1, 0, 3); hold(0, 0, 3);
        hold(1, 0, 3); hold(1, 1, 3); hold(1, 0, 3); hold(0, 0, 3);
        check_eq("abort_pulses", n_pin + n_pout + n_rej + n_err, 0);
        hold(1, 1, 5);
        check_eq("both_blocked_estado", int'(estado), 7);
        check_eq("both_blocked_err", n_err, 1);
        hold(0, 0, 2);

        // Saturation
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            hold(1, 0, 2); hold(1, 1, 2); hold(0, 1, 2); hold(0, 0, 2);
        end
        check_eq("sat_occ", int'(ocupacion), 3);
        check_eq("sat_lleno", int'(lleno), 1);
        check_eq("sat_rechazo", n_rej, 1);

        // Timeout in ENT_A
        clear_counts();
        hold(1, 0, 16);
        check_eq("to_before", int'(estado), 1);
        check_eq("to_err_before", n_err, 0);
        hold(1, 0, 1);
        check_eq("to_estado", int'(estado), 7);
        check_eq("to_err", n_err, 1);
        hold(1, 0, 13); hold(0, 0, 3);
        check_eq("to_occ", int'(ocupacion), 3);

        // Reset while in ENT_AB
        hold(1, 0, 3); hold(1, 1, 3);
        check_eq("pre_rst_estado", int'(estado), 2);
        async_reset("rst_entab");
        hold(0, 0, 2);

        // Random walk, some holds long enough to time out
        for (int k = 0; k < 120; k++) begin
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 20));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/control_estacionamiento.md
Name: control_estacionamiento

Overview:
Occupancy controller for the parking-lot counter. It takes two debounced barrier sensors, A on the outer side and B on the inner side, and sequences them through a direction-detecting FSM. A complete A→B passage counts one car in; a complete B→A passage counts one car out. It keeps a saturating occupancy count with full and empty flags and raises pulses for display and alarm logic. It sits between the per-sensor antirebote instances and the display driver.

Parameters:
CAPACIDAD, 15, maximum cars; ocupacion never exceeds this value.
ANCHO, 4, width of ocupacion; must satisfy 2**ANCHO > CAPACIDAD.
TIMEOUT, 50000000, cycles allowed in any one intermediate state before the sequence aborts; must be ≥2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sensor_a  in  1  debounced outer sensor, 1 = beam blocked; already synchronous to clk
sensor_b  in  1  debounced inner sensor, 1 = beam blocked; already synchronous to clk
ocupacion  out  ANCHO  current car count
lleno  out  1  ocupacion == CAPACIDAD
vacio  out  1  ocupacion == 0
pulso_entrada  out  1  one-cycle pulse when an entry is counted
pulso_salida  out  1  one-cycle pulse when an exit is counted
rechazo  out  1  one-cycle pulse when an entry completes while lleno
error  out  1  one-cycle pulse on an invalid sequence, timeout or exit while vacio
estado  out  3  current FSM state, for debug

Behaviour:
- Reset (async, rst_n=0): state REPOSO, ocupacion 0, vacio 1, lleno 0, all pulses 0, timer 0. Reset may arrive mid-sequence; the partial sequence is discarded.
- All outputs are registered. Each FSM step uses the (a,b) levels sampled at that edge. Counting effects and pulses are visible after the edge on which the FSM takes the completing transition.
- State encodings: REPOSO=0, ENT_A=1, ENT_AB=2, ENT_B=3, SAL_B=4, SAL_BA=5, SAL_A=6, ESPERA=7.
- Transitions, written as (a,b) → next state. Any (a,b) not listed keeps the current state.
  - REPOSO: 10→ENT_A; 01→SAL_B; 11→ESPERA with error.
  - ENT_A: 11→ENT_AB; 00→REPOSO (abort, no count); 01→ESPERA with error.
  - ENT_AB: 01→ENT_B; 10→ENT_A (car backing out); 00→ESPERA with error.
  - ENT_B: 00→REPOSO with entry event; 11→ENT_AB; 10→ESPERA with error.
  - SAL_B, SAL_BA, SAL_A: mirror of ENT_A, ENT_AB, ENT_B with a and b swapped. SAL_A 00→REPOSO with exit event.
  - ESPERA: 00→REPOSO; any other value stays. No timeout and no error while in ESPERA.
- Timer:
  - Counts cycles spent in the current state.
  - Cleared on every state change and in REPOSO and ESPERA.
  - If the timer reaches TIMEOUT−1 in an intermediate state and no listed transition fires that cycle, next state is ESPERA with error.
  - A listed transition has priority over the timeout.
- Entry event:
  - If ocupacion < CAPACIDAD: ocupacion+1, pulso_entrada=1.
  - Otherwise: ocupacion unchanged, rechazo=1.
- Exit event:
  - If ocupacion > 0: ocupacion−1, pulso_salida=1.
  - Otherwise: ocupacion unchanged, error=1.
- Only one event can occur per cycle.
- lleno and vacio are derived from the registered ocupacion and are always consistent with it in the same cycle.
- No wrap-around: the count saturates at 0 and at CAPACIDAD.
- A pulse lasts exactly one cycle even if the sensors hold their values afterwards.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle → outputs clear immediately: ocupacion=0, vacio=1, lleno=0, estado=0, all pulses 0.
2. Entry: (a,b) = 10, 11, 01, 00, each held 5 cycles → estado steps 1,2,3,0; on the final edge ocupacion=1, vacio=0, pulso_entrada high for exactly 1 cycle.
3. Exit: from ocupacion=1, apply 01, 11, 10, 00 → estado steps 4,5,6,0; ocupacion=0, vacio=1, one pulso_salida; then repeat the exit sequence → ocupacion stays 0, one error pulse.
4. Aborts:
   - 10, 00 → no pulses, ocupacion unchanged.
   - 10, 11, 10, 00 → estado steps 1,2,1,0, no count.
   - 11 from REPOSO → error pulse, estado=7, held until 00, then estado=0.
5. Saturation (CAPACIDAD=3): four full entries → ocupacion=3, lleno=1 after the third; the fourth gives rechazo=1 and ocupacion stays 3.
6. Timeout and reset (TIMEOUT=16):
   - Hold 10 for 30 cycles → error pulse on the 16th cycle in ENT_A, estado=7; release to 00 → estado=0, ocupacion unchanged.
   - rst_n pulse while in ENT_AB → estado=0 immediately, no pulses.
